// File: rtl/bus_resp_pkg.sv
// Shared constants for the memory-mapped bus responder: widths, FSM encoding,
// and the word offsets of the control registers.
package bus_resp_pkg;

  localparam int BUS_W  = 32;
  localparam int WAIT_W = 4;
  localparam int OFF_W  = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [OFF_W-1:0] OFF_WAIT  = 6'h08;
  localparam logic [OFF_W-1:0] OFF_TIMER = 6'h09;
  localparam logic [OFF_W-1:0] OFF_XFER  = 6'h0A;

  // Offsets 0x00-0x07 map onto the eight scratch registers.
  function automatic logic is_scratch(input logic [OFF_W-1:0] off);
    return off[OFF_W-1:3] == '0;
  endfunction

endpackage

// File: rtl/bus_resp_regs.sv
// Register bank behind the responder: scratch R0-R7, WAIT, free-running TIMER,
// XFER completion counter, and the combinational read mux.
module bus_resp_regs
  import bus_resp_pkg::*;
#(
  parameter logic [WAIT_W-1:0] RST_WAIT = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  logic              we,
  input  logic [OFF_W-1:0]  off,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rd_data,
  output logic [WAIT_W-1:0] wait_val
);

  logic [BUS_W-1:0]  scratch [8];
  logic [BUS_W-1:0]  timer;
  logic [BUS_W-1:0]  xfer;
  logic [WAIT_W-1:0] wait_q;
  logic              wr;

  assign wr       = acc && we;
  assign wait_val = wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) scratch[i] <= '0;
      timer  <= '0;
      xfer   <= '0;
      wait_q <= RST_WAIT;
    end else begin
      if (wr && is_scratch(off)) scratch[off[2:0]] <= wdata;
      if (wr && off == OFF_WAIT) wait_q <= wdata[WAIT_W-1:0];
      // A bus write to TIMER wins over the free-running increment.
      if (wr && off == OFF_TIMER) timer <= wdata;
      else                        timer <= timer + 1'b1;
      if (acc) xfer <= xfer + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (is_scratch(off)) begin
      rd_data = scratch[off[2:0]];
    end else begin
      case (off)
        OFF_WAIT:  rd_data = {{(BUS_W-WAIT_W){1'b0}}, wait_q};
        OFF_TIMER: rd_data = timer;
        OFF_XFER:  rd_data = xfer;
        default:   rd_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Four-phase bus responder claiming a 256-byte window; the FSM inserts the
// programmed number of wait states before acknowledging each access.
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR = 32'hFFFF_FF00,
  parameter logic [WAIT_W-1:0] RST_WAIT  = 4'd2
) (
  input  logic             i_cpu_clk,
  input  logic             i_rst,
  input  logic             i_bus_clk,
  input  logic             i_bus_we,
  input  logic [BUS_W-1:0] i_bus_addr,
  input  logic [BUS_W-1:0] i_bus_data,
  output logic [BUS_W-1:0] o_bus_data,
  output logic             o_bus_data_ready,
  output logic             o_sel
);

  logic [1:0]        state;
  logic [WAIT_W:0]   cnt;
  logic [OFF_W-1:0]  off_q;
  logic              we_q;
  logic [BUS_W-1:0]  wdata_q;
  logic              hit;
  logic              accept;
  logic              enter_ack;
  logic [WAIT_W-1:0] wait_val;
  logic [BUS_W-1:0]  rd_data;
  logic              unused_addr_lsb;

  assign hit             = i_bus_addr[31:8] == BASE_ADDR[31:8];
  assign accept          = (state == ST_IDLE) && i_bus_clk && hit;
  assign enter_ack       = (state == ST_WAIT) && i_bus_clk && (cnt == 1);
  assign unused_addr_lsb = ^i_bus_addr[1:0];

  assign o_sel            = (state != ST_IDLE);
  assign o_bus_data_ready = (state == ST_ACK);

  // Counter is loaded with W+1 so that ACK lands exactly W+1 edges after capture.
  always_ff @(posedge i_cpu_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_WAIT;
            cnt   <= {1'b0, wait_val} + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!i_bus_clk)    state <= ST_IDLE;
          else if (cnt == 1) state <= ST_ACK;
          else               cnt   <= cnt - 1'b1;
        end
        ST_ACK: begin
          if (!i_bus_clk) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_cpu_clk) begin
    if (accept) begin
      off_q   <= i_bus_addr[7:2];
      we_q    <= i_bus_we;
      wdata_q <= i_bus_data;
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_rst) begin
    if (!i_rst)                  o_bus_data <= '0;
    else if (enter_ack && !we_q) o_bus_data <= rd_data;
  end

  bus_resp_regs #(
    .RST_WAIT (RST_WAIT)
  ) u_regs (
    .clk      (i_cpu_clk),
    .rst_n    (i_rst),
    .acc      (enter_ack),
    .we       (we_q),
    .off      (off_q),
    .wdata    (wdata_q),
    .rd_data  (rd_data),
    .wait_val (wait_val)
  );

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'hFFFF_FF00, meaning the base of the 256-byte window claimed by this responder.
REQ-002 The module SHALL have parameter RST_WAIT, default 4'd2, meaning the wait-state count loaded at reset.
REQ-003 The module SHALL have port i_cpu_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_bus_clk, input, 1 bit: bus request strobe driven by the CPU.
REQ-006 The module SHALL have port i_bus_we, input, 1 bit: 1 for write, 0 for read.
REQ-007 The module SHALL have port i_bus_addr, input, 32 bits: byte address.
REQ-008 The module SHALL have port i_bus_data, input, 32 bits: write data.
REQ-009 The module SHALL have port o_bus_data, output, 32 bits: read data.
REQ-010 The module SHALL have port o_bus_data_ready, output, 1 bit: completion acknowledge.
REQ-011 The module SHALL have port o_sel, output, 1 bit: a transaction in this window is in progress.

Function
REQ-012 Hit SHALL be defined as i_bus_addr[31:8] == BASE_ADDR[31:8], with the word offset taken from i_bus_addr[7:2]; address bits [1:0] SHALL be ignored.
REQ-013 The handshake SHALL be four-phase: CPU raises i_bus_clk; responder raises o_bus_data_ready; CPU drops i_bus_clk; responder drops o_bus_data_ready.
REQ-014 The FSM SHALL have the states IDLE, WAIT, ACK.
REQ-015 In IDLE with i_bus_clk=1 and a hit, the module SHALL capture addr, we and data, load the wait counter from the WAIT register, and go to WAIT, or go directly to ACK if the count is 0.
REQ-016 In IDLE with a miss, the module SHALL stay in IDLE and o_bus_data_ready SHALL stay 0.
REQ-017 In WAIT, the module SHALL decrement the counter each cycle and enter ACK on the edge where the counter would reach 0.
REQ-018 If i_bus_clk falls during WAIT, the transaction SHALL be abandoned: no register update, and the FSM returns to IDLE.
REQ-019 Latency: with i_bus_clk first sampled high at edge n, o_bus_data_ready SHALL rise at edge n+1+W, where W is the WAIT value captured at edge n.
REQ-020 On the edge entering ACK, the module SHALL perform the write, or load o_bus_data for a read, and increment the XFER counter.
REQ-021 In ACK, o_bus_data_ready and o_bus_data SHALL hold until i_bus_clk is sampled 0; on that edge ready SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as that return to IDLE.
REQ-023 o_sel SHALL be 1 in WAIT and ACK, and 0 in IDLE.
REQ-024 The register map (word offsets) SHALL be:
- 0x00-0x07: R0-R7, 32-bit read/write scratch.
- 0x08: WAIT, bits [3:0] read/write; upper bits read 0, writes to them ignored.
- 0x09: TIMER, free-running 32-bit up-counter; a write loads it.
- 0x0A: XFER, read-only 32-bit count of completed ACKs; writes ignored.
REQ-025 The TIMER SHALL increment every cycle and wrap from FFFF_FFFF to 0; a write SHALL take precedence over the increment on that edge.
REQ-026 XFER SHALL wrap from FFFF_FFFF to 0, SHALL count both reads and writes, and a read of XFER SHALL return the pre-increment value.
REQ-027 Unmapped offsets 0x0B-0x3F SHALL read 0, ignore writes, and still be acknowledged.
REQ-028 A WAIT write SHALL affect only subsequent transactions.
REQ-029 o_bus_data SHALL hold its last value outside ACK.

Reset
REQ-030 Asserting i_rst low SHALL immediately force:
- FSM to IDLE;
- o_bus_data_ready=0, o_sel=0, o_bus_data=0;
- R0-R7, TIMER and XFER to 0;
- WAIT to RST_WAIT.
REQ-031 Reset asserted mid-transaction SHALL discard that transaction with no register write.
REQ-032 After reset release, the first request SHALL be accepted on the first edge with i_bus_clk=1.

Structure
REQ-033 A shared package bus_resp_pkg SHALL hold the bus width (32), the FSM state encoding, the register offset constants, and the WAIT field width.
REQ-034 The register bank (R0-R7, WAIT, TIMER, XFER, read mux) SHALL be one sub-module, bus_resp_regs; the FSM and wait counter SHALL reside in bus_responder.

Verification
REQ-035 Scenario 1: WAIT=2, write 32'hDEADBEEF to BASE+0x04, then read BASE+0x04 -> ready rises at edge n+3 both times, and the read returns DEADBEEF.
REQ-036 Scenario 2: write WAIT=0, then read BASE+0x20 -> ready at edge n+1, and the value read is 0000_0000.
REQ-037 Scenario 3: request to address 0x0000_1000 (miss) -> o_sel and o_bus_data_ready stay 0 for 20 cycles.
REQ-038 Scenario 4: WAIT=5, drop i_bus_clk after 2 cycles of a write of 0x1234 to R0 -> R0 unchanged, and XFER unchanged.
REQ-039 Scenario 5: write TIMER=FFFF_FFFE, then read TIMER with WAIT=0 -> the value reflects the wrap through 0, and XFER increments by exactly 2.
REQ-040 Scenario 6: assert i_rst during ACK of a write to R3=0xA5 -> ready falls at once, R3=0, and WAIT=2.
